// File: rtl/conversor_bcd_binario.sv
// Sequential BCD-to-binary converter: seven packed BCD digits are turned into a
// binary value by 28 iterations of reverse double-dabble (shift right, subtract 3).
module conversor_bcd_binario #(
  parameter int LARGURA_SAIDA = 32
) (
  input  logic                     Clock,
  input  logic                     Resetn,
  input  logic                     Iniciar,
  input  logic [3:0]               Milhao,
  input  logic [3:0]               CentMilhar,
  input  logic [3:0]               DezMilhar,
  input  logic [3:0]               UniMilhar,
  input  logic [3:0]               Centena,
  input  logic [3:0]               Dezena,
  input  logic [3:0]               Unidade,
  output logic [LARGURA_SAIDA-1:0] Saida,
  output logic                     Pronto,
  output logic                     Ocupado,
  output logic                     Erro
);

  typedef enum logic {
    OCIOSO,
    CONVERTE
  } state_t;

  state_t state_reg, state_next;

  logic [27:0]              bcd_reg;
  logic [27:0]              bin_reg;
  logic [4:0]               count_reg;
  logic                     reject_reg;
  logic [LARGURA_SAIDA-1:0] saida_reg;
  logic                     pronto_reg;
  logic                     ocupado_reg;
  logic                     erro_reg;

  logic [27:0] digits;
  logic [6:0]  nib_invalid;
  logic        any_invalid;
  logic [55:0] shifted;
  logic [27:0] bcd_shift;
  logic [27:0] bin_shift;
  logic [27:0] bcd_adj;

  logic start_ok;
  logic reject;
  logic last_iter;

  assign digits = {Milhao, CentMilhar, DezMilhar, UniMilhar, Centena, Dezena, Unidade};

  // One iteration: BCD LSB falls into the binary MSB, then each BCD nibble that
  // reached 8 or more is corrected by 3 (the inverse of the add-3 step).
  assign shifted   = {bcd_reg, bin_reg} >> 1;
  assign bcd_shift = shifted[55:28];
  assign bin_shift = shifted[27:0];

  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_nibble
      assign nib_invalid[gi] = (digits[gi*4 +: 4] > 4'd9);
      assign bcd_adj[gi*4 +: 4] = (bcd_shift[gi*4 +: 4] >= 4'd8) ?
                                  (bcd_shift[gi*4 +: 4] - 4'd3) :
                                  bcd_shift[gi*4 +: 4];
    end
  endgenerate

  assign any_invalid = |nib_invalid;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_reg <= OCIOSO;
    end else begin
      state_reg <= state_next;
    end
  end

  // A rejection is latched for one cycle so its outputs appear on the edge after
  // the request; new requests are not taken while that report is pending.
  always_comb begin
    state_next = state_reg;
    start_ok   = 1'b0;
    reject     = 1'b0;
    last_iter  = 1'b0;
    case (state_reg)
      OCIOSO: begin
        if (Iniciar && !reject_reg) begin
          if (any_invalid) begin
            reject = 1'b1;
          end else begin
            start_ok   = 1'b1;
            state_next = CONVERTE;
          end
        end
      end
      CONVERTE: begin
        if (count_reg == 5'd27) begin
          last_iter  = 1'b1;
          state_next = OCIOSO;
        end
      end
      default: state_next = OCIOSO;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      bcd_reg     <= '0;
      bin_reg     <= '0;
      count_reg   <= '0;
      reject_reg  <= 1'b0;
      saida_reg   <= '0;
      pronto_reg  <= 1'b0;
      ocupado_reg <= 1'b0;
      erro_reg    <= 1'b0;
    end else begin
      pronto_reg <= 1'b0;
      reject_reg <= reject;
      if (reject_reg) begin
        erro_reg   <= 1'b1;
        saida_reg  <= '0;
        pronto_reg <= 1'b1;
      end
      if (start_ok) begin
        bcd_reg     <= digits;
        bin_reg     <= '0;
        count_reg   <= '0;
        erro_reg    <= 1'b0;
        ocupado_reg <= 1'b1;
      end else if (state_reg == CONVERTE) begin
        bcd_reg   <= bcd_adj;
        bin_reg   <= bin_shift;
        count_reg <= count_reg + 5'd1;
        if (last_iter) begin
          // 9 999 999 fits in 24 bits, so the upper binary bits are always zero.
          saida_reg   <= LARGURA_SAIDA'(bin_shift[23:0]);
          pronto_reg  <= 1'b1;
          ocupado_reg <= 1'b0;
        end
      end
    end
  end

  assign Saida   = saida_reg;
  assign Pronto  = pronto_reg;
  assign Ocupado = ocupado_reg;
  assign Erro    = erro_reg;

endmodule

// File: tb/tb_conversor_bcd_binario.sv
// Scoreboard bench for conversor_bcd_binario: stimulus pushes expected results,
// a negedge monitor pops them on Pronto and tracks Saida/Erro/Ocupado every cycle.
module tb_conversor_bcd_binario;

  logic        Clock;
  logic        Resetn;
  logic        Iniciar;
  logic [3:0]  Milhao, CentMilhar, DezMilhar, UniMilhar, Centena, Dezena, Unidade;
  logic [31:0] Saida;
  logic        Pronto, Ocupado, Erro;

  conversor_bcd_binario #(.LARGURA_SAIDA(32)) dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .Iniciar    (Iniciar),
    .Milhao     (Milhao),
    .CentMilhar (CentMilhar),
    .DezMilhar  (DezMilhar),
    .UniMilhar  (UniMilhar),
    .Centena    (Centena),
    .Dezena     (Dezena),
    .Unidade    (Unidade),
    .Saida      (Saida),
    .Pronto     (Pronto),
    .Ocupado    (Ocupado),
    .Erro       (Erro)
  );

  typedef struct {
    int cyc;
    int val;
    bit err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   exp_saida = 0;
  bit   exp_erro = 1'b0;
  int   valid_start = -1;

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  always @(posedge Clock) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h need %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference: decimal value by plain positional arithmetic.
  task automatic model(input logic [27:0] d, output bit err, output int val);
    int p;
    int nib;
    err = 1'b0;
    val = 0;
    p = 1;
    for (int k = 0; k < 7; k++) begin
      nib = int'(d[4*k +: 4]);
      if (nib > 9) err = 1'b1;
      val = val + nib * p;
      p = p * 10;
    end
    if (err) val = 0;
  endtask

  // Monitor
  initial begin
    exp_t e;
    bit   busy;
    forever begin
      @(negedge Clock);
      if (!Resetn) begin
        chk("reset_saida", Saida, 32'd0);
        chk("reset_pronto", {31'd0, Pronto}, 32'd0);
        chk("reset_ocupado", {31'd0, Ocupado}, 32'd0);
        chk("reset_erro", {31'd0, Erro}, 32'd0);
      end else begin
        if (valid_start >= 0 && cyc == valid_start) exp_erro = 1'b0;
        busy = (valid_start >= 0) && (cyc >= valid_start) && (cyc < valid_start + 28);
        chk("ocupado", {31'd0, Ocupado}, {31'd0, busy});
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
          e = sb.pop_front();
          total++;
          bad++;
          $display("FAIL pronto_missing: got none need pulse at cycle %0d (now %0d)", e.cyc, cyc);
        end
        if (Pronto === 1'b1) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pronto_unexpected: got pulse need none (cycle %0d)", cyc);
          end else begin
            e = sb.pop_front();
            chk("pronto_cycle", cyc, e.cyc);
            exp_saida = e.val;
            exp_erro  = e.err;
            $display("result: cycle=%0d saida=%0d erro=%0b expected=%0d/%0b",
                     cyc, Saida, Erro, e.val, e.err);
          end
        end
        chk("saida", Saida, exp_saida);
        chk("erro", {31'd0, Erro}, {31'd0, exp_erro});
      end
    end
  end

  task automatic tick();
    @(negedge Clock);
    #1;
  endtask

  task automatic issue(input logic [27:0] d, output int e0);
    bit   err;
    int   val;
    exp_t e;
    {Milhao, CentMilhar, DezMilhar, UniMilhar, Centena, Dezena, Unidade} = d;
    Iniciar = 1'b1;
    model(d, err, val);
    e0 = cyc + 1;
    e.cyc = err ? e0 + 1 : e0 + 28;
    e.val = val;
    e.err = err;
    sb.push_back(e);
    if (!err) valid_start = e0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) return;
      tick();
    end
    total++;
    bad++;
    $display("FAIL timeout: got %0d pending results need 0", sb.size());
    sb.delete();
  endtask

  task automatic do_req(input logic [27:0] d);
    int e0;
    issue(d, e0);
    tick();
    Iniciar = 1'b0;
    wait_idle();
  endtask

  initial begin
    int          e0;
    exp_t        e;
    logic [27:0] d;
    Resetn  = 1'b0;
    Iniciar = 1'b0;
    {Milhao, CentMilhar, DezMilhar, UniMilhar, Centena, Dezena, Unidade} = '0;
    repeat (3) tick();
    Resetn = 1'b1;
    tick();

    do_req(28'h0000000);
    do_req(28'h1234567);
    do_req(28'h9999999);
    do_req(28'h0000001);
    do_req(28'h0000A00);
    do_req(28'h0000042);

    // Iniciar held high: second request accepted at the first idle edge.
    issue(28'h0000042, e0);
    for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
    e.cyc = e0 + 29 + 28;
    e.val = 42;
    e.err = 1'b0;
    sb.push_back(e);
    valid_start = e0 + 29;
    tick();
    Iniciar = 1'b0;
    wait_idle();

    // Request during conversion is ignored.
    issue(28'h1234567, e0);
    tick();
    Iniciar = 1'b0;
    while (cyc < e0 + 9) tick();
    {Milhao, CentMilhar, DezMilhar, UniMilhar, Centena, Dezena, Unidade} = 28'h9999999;
    Iniciar = 1'b1;
    tick();
    Iniciar = 1'b0;
    wait_idle();
    repeat (35) tick();

    // Reset mid-conversion discards the result.
    issue(28'h9999999, e0);
    tick();
    Iniciar = 1'b0;
    while (cyc < e0 + 14) tick();
    Resetn = 1'b0;
    sb.delete();
    exp_saida   = 0;
    exp_erro    = 1'b0;
    valid_start = -1;
    tick();
    tick();
    Resetn = 1'b1;
    repeat (35) tick();
    do_req(28'h9999999);

    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < 7; k++) d[4*k +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 7) == 0) begin
        d[4*$urandom_range(0, 6) +: 4] = 4'($urandom_range(10, 15));
      end
      do_req(d);
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (35) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
